// File: rtl/dcache_mon_pkg.sv
// Shared definitions for dcache_event_monitor: event type encoding, the
// buffered event record layout and a saturating increment helper.
package dcache_mon_pkg;

  localparam int unsigned EVT_TYPE_W = 3;
  localparam int unsigned EVT_ADDR_W = 32;
  localparam int unsigned EVT_DATA_W = 32;
  localparam int unsigned EVT_CNT_W  = 32;
  localparam int unsigned SAT_W      = 64;

  typedef enum logic [EVT_TYPE_W-1:0] {
    RD_HIT     = 3'd0,
    RD_MISS    = 3'd1,
    WR_HIT     = 3'd2,
    WR_MISS    = 3'd3,
    RD_MISS_WB = 3'd4,
    WR_MISS_WB = 3'd5
  } evt_type_e;

  // One buffered event; field widths follow the package widths above.
  typedef struct packed {
    evt_type_e               typ;
    logic [EVT_ADDR_W-1:0]   addr;
    logic [EVT_DATA_W-1:0]   data;
    logic [EVT_CNT_W-1:0]    cycle;
  } evt_rec_t;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                               input logic [SAT_W-1:0] max_val);
    return (val >= max_val) ? val : val + SAT_W'(1);
  endfunction

endpackage

// File: rtl/dcache_mon_fifo.sv
// Synchronous FIFO for event records. Depth must be a power of two so the
// pointers wrap naturally. A push into a full FIFO is dropped unless a pop
// happens in the same cycle.
module dcache_mon_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  // Flags, accepted push/pop and head read
  always_comb begin
    empty_o = (count_q == '0);
    full_o  = (count_q == CW'(DEPTH));
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    drop_c  = push_i & ~do_push;
    data_o  = mem_q[rd_ptr_q];
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Record storage; contents are only observed while non-empty
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/dcache_event_monitor.sv
// Data-cache event monitor: classifies each CPU-side access as hit, miss or
// miss-with-writeback, keeps saturating counters and a cycle counter, pulses
// a flush request at FLUSH_CYCLE and optionally buffers event records.
// Optional feature macro: DCACHE_MON_FIFO_EN (event FIFO and evt_* outputs).
import dcache_mon_pkg::*;

module dcache_event_monitor #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned FLUSH_CYCLE = 150
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic              stall_i,
  input  logic              fsm_idle_i,
  input  logic              dirty_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [CNT_W-1:0]  cycle_cnt_o,
  output logic [CNT_W-1:0]  rd_hit_cnt_o,
  output logic [CNT_W-1:0]  rd_miss_cnt_o,
  output logic [CNT_W-1:0]  wr_hit_cnt_o,
  output logic [CNT_W-1:0]  wr_miss_cnt_o,
  output logic [CNT_W-1:0]  wb_cnt_o,
  output logic              flush_req_o,
  output logic              done_o,
  output logic              evt_valid_o,
  input  logic              evt_ready_i,
  output logic [2:0]        evt_type_o,
  output logic [ADDR_W-1:0] evt_addr_o,
  output logic [DATA_W-1:0] evt_data_o,
  output logic [CNT_W-1:0]  evt_cycle_o,
  output logic              evt_overflow_o
);

  localparam logic [SAT_W-1:0] CNT_MAX  = SAT_W'({CNT_W{1'b1}});
  localparam logic [CNT_W-1:0] FLUSH_AT = CNT_W'(FLUSH_CYCLE);

  logic             access;
  logic             is_wr;
  logic             miss;
  logic             hit;
  logic             flag_q;
  logic             done_q;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] cycle_nxt;
  logic [CNT_W-1:0] rd_hit_q;
  logic [CNT_W-1:0] rd_miss_q;
  logic [CNT_W-1:0] wr_hit_q;
  logic [CNT_W-1:0] wr_miss_q;
  logic [CNT_W-1:0] wb_q;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(SAT_W'(v), CNT_MAX));
  endfunction

  // Access classification; the flag stops a stalled miss being counted twice
  always_comb begin
    access = mem_read_i | mem_write_i;
    is_wr  = mem_write_i;
    miss   = en_i & stall_i & fsm_idle_i & access & ~flag_q;
    hit    = en_i & ~stall_i & ~flag_q & access;
  end

  // Next cycle-counter value, also used to set done at the same edge
  always_comb begin
    cycle_nxt = cycle_q;
    if (rst_i || clr_i) cycle_nxt = CNT_W'(1);
    else if (en_i)      cycle_nxt = cnt_inc(cycle_q);
  end

  // Cycle counter, miss flag and event counters
  always_ff @(posedge clk_i) begin
    cycle_q <= cycle_nxt;
    if (rst_i || clr_i) begin
      flag_q    <= 1'b0;
      rd_hit_q  <= '0;
      rd_miss_q <= '0;
      wr_hit_q  <= '0;
      wr_miss_q <= '0;
      wb_q      <= '0;
    end else begin
      if (!stall_i)  flag_q <= 1'b0;
      else if (miss) flag_q <= 1'b1;
      if (hit && !is_wr)   rd_hit_q  <= cnt_inc(rd_hit_q);
      if (hit && is_wr)    wr_hit_q  <= cnt_inc(wr_hit_q);
      if (miss && !is_wr)  rd_miss_q <= cnt_inc(rd_miss_q);
      if (miss && is_wr)   wr_miss_q <= cnt_inc(wr_miss_q);
      if (miss && dirty_i) wb_q      <= cnt_inc(wb_q);
    end
  end

  // Sticky done, cleared only by reset
  always_ff @(posedge clk_i) begin
    if (rst_i)                      done_q <= 1'b0;
    else if (cycle_nxt > FLUSH_AT)  done_q <= 1'b1;
  end

  assign flush_req_o   = en_i & (cycle_q == FLUSH_AT);
  assign done_o        = done_q;
  assign cycle_cnt_o   = cycle_q;
  assign rd_hit_cnt_o  = rd_hit_q;
  assign rd_miss_cnt_o = rd_miss_q;
  assign wr_hit_cnt_o  = wr_hit_q;
  assign wr_miss_cnt_o = wr_miss_q;
  assign wb_cnt_o      = wb_q;

`ifdef DCACHE_MON_FIFO_EN
  localparam int unsigned REC_W = $bits(evt_rec_t);

  evt_rec_t         rec_in;
  evt_rec_t         rec_head;
  logic [REC_W-1:0] head_bits;
  logic             push;
  logic             fifo_empty;
  logic             fifo_drop;
  logic             unused_full;
  logic             ovf_q;

  // Build the record for this cycle's event; clear suppresses the push
  always_comb begin
    push         = (hit | miss) & ~clr_i;
    rec_in.addr  = EVT_ADDR_W'(addr_i);
    rec_in.data  = is_wr ? EVT_DATA_W'(wdata_i) : EVT_DATA_W'(rdata_i);
    rec_in.cycle = EVT_CNT_W'(cycle_q);
    if (hit)          rec_in.typ = is_wr ? WR_HIT : RD_HIT;
    else if (dirty_i) rec_in.typ = is_wr ? WR_MISS_WB : RD_MISS_WB;
    else              rec_in.typ = is_wr ? WR_MISS : RD_MISS;
  end

  dcache_mon_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (rec_in),
    .pop_i   (evt_ready_i),
    .data_o  (head_bits),
    .full_o  (unused_full),
    .empty_o (fifo_empty),
    .drop_c  (fifo_drop)
  );

  assign rec_head = evt_rec_t'(head_bits);

  // Sticky overflow on a dropped push
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) ovf_q <= 1'b0;
    else if (fifo_drop) ovf_q <= 1'b1;
  end

  // Head payload, forced to zero while the FIFO is empty
  always_comb begin
    evt_valid_o    = ~fifo_empty;
    evt_overflow_o = ovf_q;
    evt_type_o     = '0;
    evt_addr_o     = '0;
    evt_data_o     = '0;
    evt_cycle_o    = '0;
    if (evt_valid_o) begin
      evt_type_o  = rec_head.typ;
      evt_addr_o  = ADDR_W'(rec_head.addr);
      evt_data_o  = DATA_W'(rec_head.data);
      evt_cycle_o = CNT_W'(rec_head.cycle);
    end
  end
`else
  localparam int unsigned unused_depth = FIFO_DEPTH;

  logic unused_ok;
  assign unused_ok = ^{evt_ready_i, addr_i, wdata_i, rdata_i};

  // Event buffering is compiled out; the handshake outputs stay idle
  always_comb begin
    evt_valid_o    = 1'b0;
    evt_overflow_o = 1'b0;
    evt_type_o     = '0;
    evt_addr_o     = '0;
    evt_data_o     = '0;
    evt_cycle_o    = '0;
  end
`endif

endmodule

// File: tb/tb_dcache_event_monitor.sv
// Bench for dcache_event_monitor: directed scenarios plus a randomized run
// checked against a cycle-level reference model of the event rules.
module tb_dcache_event_monitor;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned FLUSH  = 150;
`ifdef DCACHE_MON_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0, en_i = 1'b0, clr_i = 1'b0, stall_i = 1'b0;
  logic              fsm_idle_i = 1'b0, dirty_i = 1'b0;
  logic              mem_read_i = 1'b0, mem_write_i = 1'b0, evt_ready_i = 1'b0;
  logic [ADDR_W-1:0] addr_i = '0;
  logic [DATA_W-1:0] wdata_i = '0, rdata_i = '0;
  logic [CNT_W-1:0]  cycle_cnt_o, rd_hit_cnt_o, rd_miss_cnt_o, wr_hit_cnt_o;
  logic [CNT_W-1:0]  wr_miss_cnt_o, wb_cnt_o, evt_cycle_o;
  logic              flush_req_o, done_o, evt_valid_o, evt_overflow_o;
  logic [2:0]        evt_type_o;
  logic [ADDR_W-1:0] evt_addr_o;
  logic [DATA_W-1:0] evt_data_o;

  int checks = 0;
  int failures = 0;

  dcache_event_monitor #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W),
    .FIFO_DEPTH(DEPTH), .FLUSH_CYCLE(FLUSH)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .clr_i(clr_i),
    .stall_i(stall_i), .fsm_idle_i(fsm_idle_i), .dirty_i(dirty_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rdata_i(rdata_i), .cycle_cnt_o(cycle_cnt_o),
    .rd_hit_cnt_o(rd_hit_cnt_o), .rd_miss_cnt_o(rd_miss_cnt_o),
    .wr_hit_cnt_o(wr_hit_cnt_o), .wr_miss_cnt_o(wr_miss_cnt_o),
    .wb_cnt_o(wb_cnt_o), .flush_req_o(flush_req_o), .done_o(done_o),
    .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i),
    .evt_type_o(evt_type_o), .evt_addr_o(evt_addr_o), .evt_data_o(evt_data_o),
    .evt_cycle_o(evt_cycle_o), .evt_overflow_o(evt_overflow_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- reference model ----------------
  typedef struct {
    logic [2:0]  t;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] c;
  } rec_t;

  rec_t        m_q[$];
  logic [31:0] m_cyc = 32'd1;
  logic [31:0] m_rdh = 0, m_rdm = 0, m_wrh = 0, m_wrm = 0, m_wb = 0;
  bit          m_flag = 0, m_ovf = 0, m_done = 0;

  function automatic logic [31:0] sat(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  // Apply one clock edge worth of behaviour using the currently driven inputs
  task automatic model_step();
    bit   acc, miss, hit, pop;
    rec_t r;
    acc = mem_read_i || mem_write_i;
    if (rst_i) begin
      m_cyc = 1; m_rdh = 0; m_rdm = 0; m_wrh = 0; m_wrm = 0; m_wb = 0;
      m_flag = 0; m_ovf = 0; m_done = 0; m_q.delete();
      return;
    end
    pop = FIFO_EN && evt_ready_i && (m_q.size() > 0);
    if (pop) void'(m_q.pop_front());
    if (clr_i) begin
      m_cyc = 1; m_rdh = 0; m_rdm = 0; m_wrh = 0; m_wrm = 0; m_wb = 0;
      m_flag = 0; m_ovf = 0;
      return;
    end
    miss = en_i && stall_i && fsm_idle_i && acc && !m_flag;
    hit  = en_i && !stall_i && !m_flag && acc;
    if (FIFO_EN && (hit || miss)) begin
      if (hit)          r.t = mem_write_i ? 3'd2 : 3'd0;
      else if (dirty_i) r.t = mem_write_i ? 3'd5 : 3'd4;
      else              r.t = mem_write_i ? 3'd3 : 3'd1;
      r.a = addr_i;
      r.d = mem_write_i ? wdata_i : rdata_i;
      r.c = m_cyc;
      if (m_q.size() < DEPTH) m_q.push_back(r);
      else m_ovf = 1;
    end
    if (hit && !mem_write_i)  m_rdh = sat(m_rdh);
    if (hit && mem_write_i)   m_wrh = sat(m_wrh);
    if (miss && !mem_write_i) m_rdm = sat(m_rdm);
    if (miss && mem_write_i)  m_wrm = sat(m_wrm);
    if (miss && dirty_i)      m_wb  = sat(m_wb);
    if (!stall_i)  m_flag = 0;
    else if (miss) m_flag = 1;
    if (en_i) m_cyc = sat(m_cyc);
    if (m_cyc > FLUSH) m_done = 1;
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 2 time units after posedge
  task automatic tick();
    model_step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic set_idle(input logic en);
    en_i = en; clr_i = 0; stall_i = 0; fsm_idle_i = 0; dirty_i = 0;
    mem_read_i = 0; mem_write_i = 0; evt_ready_i = 0;
    addr_i = '0; wdata_i = '0; rdata_i = '0;
  endtask

  task automatic do_reset();
    set_idle(1'b0);
    rst_i = 1; tick(); tick(); rst_i = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (cycle_cnt_o !== 32'd1) begin failures++; $display("FAIL reset_cycle got=%0d exp=1", cycle_cnt_o); end
    checks++; if ({rd_hit_cnt_o, rd_miss_cnt_o, wr_hit_cnt_o, wr_miss_cnt_o, wb_cnt_o} !== 160'd0) begin
      failures++; $display("FAIL reset_counters got=%0h exp=0", {rd_hit_cnt_o, rd_miss_cnt_o, wr_hit_cnt_o, wr_miss_cnt_o, wb_cnt_o}); end
    checks++; if ({flush_req_o, done_o, evt_valid_o, evt_overflow_o} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {flush_req_o, done_o, evt_valid_o, evt_overflow_o}); end
    checks++; if ({evt_type_o, evt_addr_o, evt_data_o, evt_cycle_o} !== 99'd0) begin
      failures++; $display("FAIL reset_payload got=%0h exp=0", {evt_type_o, evt_addr_o, evt_data_o, evt_cycle_o}); end
    en_i = 1;
    repeat (10) tick();
    checks++; if (cycle_cnt_o !== 32'd11) begin failures++; $display("FAIL idle_cycle got=%0d exp=11", cycle_cnt_o); end
    checks++; if ({rd_hit_cnt_o, rd_miss_cnt_o, wr_hit_cnt_o, wr_miss_cnt_o, wb_cnt_o} !== 160'd0) begin
      failures++; $display("FAIL idle_counters got=%0h exp=0", {rd_hit_cnt_o, rd_miss_cnt_o, wr_hit_cnt_o, wr_miss_cnt_o, wb_cnt_o}); end
    checks++; if (evt_valid_o !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b exp=0", evt_valid_o); end
  endtask

  task automatic test_read_hit();
    set_idle(1'b1);
    mem_read_i = 1; addr_i = 32'h0; rdata_i = 32'h5;
    tick();
    set_idle(1'b1);
    #1;
    checks++; if (rd_hit_cnt_o !== 32'd1) begin failures++; $display("FAIL hit_count got=%0d exp=1", rd_hit_cnt_o); end
    checks++; if (evt_valid_o !== FIFO_EN) begin failures++; $display("FAIL hit_valid got=%b exp=%b", evt_valid_o, FIFO_EN); end
    checks++; if ({evt_type_o, evt_addr_o, evt_data_o, evt_cycle_o} !== (FIFO_EN ? {3'd0, 32'h0, 32'h5, 32'd11} : 99'd0)) begin
      failures++; $display("FAIL hit_record got=%0h/%0h/%0h/%0d exp=0/0/5/11", evt_type_o, evt_addr_o, evt_data_o, evt_cycle_o); end
    evt_ready_i = 1; tick(); evt_ready_i = 0;
    #1;
    checks++; if (evt_valid_o !== 1'b0) begin failures++; $display("FAIL hit_drained got=%b exp=0", evt_valid_o); end
  endtask

  task automatic test_write_miss_wb();
    set_idle(1'b1);
    mem_write_i = 1; addr_i = 32'h400; wdata_i = 32'hDEAD_BEEF; dirty_i = 1; stall_i = 1;
    for (int c = 1; c <= 4; c++) begin
      fsm_idle_i = (c == 1 || c == 4);
      tick();
    end
    stall_i = 0; fsm_idle_i = 1;
    tick();
    set_idle(1'b1);
    #1;
    checks++; if (wr_miss_cnt_o !== 32'd1) begin failures++; $display("FAIL wmiss_count got=%0d exp=1", wr_miss_cnt_o); end
    checks++; if (wb_cnt_o !== 32'd1) begin failures++; $display("FAIL wmiss_wb got=%0d exp=1", wb_cnt_o); end
    checks++; if (wr_hit_cnt_o !== 32'd0) begin failures++; $display("FAIL wmiss_nohit got=%0d exp=0", wr_hit_cnt_o); end
    checks++; if ({evt_valid_o, evt_type_o, evt_addr_o, evt_data_o} !== (FIFO_EN ? {1'b1, 3'd5, 32'h400, 32'hDEAD_BEEF} : 68'd0)) begin
      failures++; $display("FAIL wmiss_record got=%b/%0d/%0h/%0h exp=type5 addr400", evt_valid_o, evt_type_o, evt_addr_o, evt_data_o); end
    evt_ready_i = 1; tick(); evt_ready_i = 0;
    #1;
    checks++; if (evt_valid_o !== 1'b0) begin failures++; $display("FAIL wmiss_single got=%b exp=0", evt_valid_o); end
  endtask

  task automatic test_overflow();
    logic [31:0] dat [10];
    set_idle(1'b1);
    clr_i = 1; tick(); clr_i = 0;
    for (int i = 0; i < 10; i++) begin
      dat[i] = $urandom;
      mem_read_i = 1; addr_i = 32'h100 + 32'(i * 4); rdata_i = dat[i];
      tick();
    end
    set_idle(1'b1);
    #1;
    checks++; if (rd_hit_cnt_o !== 32'd10) begin failures++; $display("FAIL ovf_hits got=%0d exp=10", rd_hit_cnt_o); end
    checks++; if ({evt_valid_o, evt_overflow_o} !== {FIFO_EN, FIFO_EN}) begin
      failures++; $display("FAIL ovf_flags got=%b%b exp=%b%b", evt_valid_o, evt_overflow_o, FIFO_EN, FIFO_EN); end
    evt_ready_i = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if ({evt_valid_o, evt_addr_o, evt_data_o} !== (FIFO_EN ? {1'b1, 32'h100 + 32'(i * 4), dat[i]} : 65'd0)) begin
        failures++; $display("FAIL ovf_drain%0d got=%b/%0h/%0h exp=%0h/%0h", i, evt_valid_o, evt_addr_o, evt_data_o, 32'h100 + 32'(i * 4), dat[i]); end
      tick();
    end
    evt_ready_i = 0;
    #1;
    checks++; if (evt_valid_o !== 1'b0) begin failures++; $display("FAIL ovf_empty got=%b exp=0", evt_valid_o); end
  endtask

  task automatic test_back_to_back();
    set_idle(1'b1);
    clr_i = 1; tick(); clr_i = 0;
    for (int i = 0; i < 9; i++) begin
      mem_read_i = 1; addr_i = 32'h2000 + 32'(i); rdata_i = 32'(i);
      evt_ready_i = (i == 8);
      tick();
    end
    set_idle(1'b1);
    #1;
    checks++; if (evt_overflow_o !== 1'b0) begin failures++; $display("FAIL b2b_ovf got=%b exp=0", evt_overflow_o); end
    evt_ready_i = 1;
    for (int i = 1; i < 9; i++) begin
      #1;
      checks++; if ({evt_valid_o, evt_addr_o} !== (FIFO_EN ? {1'b1, 32'h2000 + 32'(i)} : 33'd0)) begin
        failures++; $display("FAIL b2b_head%0d got=%b/%0h exp=%0h", i, evt_valid_o, evt_addr_o, 32'h2000 + 32'(i)); end
      tick();
    end
    evt_ready_i = 0;
    #1;
    checks++; if (evt_valid_o !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", evt_valid_o); end
  endtask

  task automatic test_flush();
    int pulses;
    do_reset();
    en_i = 1;
    for (int g = 0; g < 300 && m_cyc != 32'd149; g++) tick();
    #1;
    checks++; if ({cycle_cnt_o, flush_req_o} !== {32'd149, 1'b0}) begin
      failures++; $display("FAIL flush_pre got=%0d/%b exp=149/0", cycle_cnt_o, flush_req_o); end
    tick();
    en_i = 0;
    #1;
    checks++; if (flush_req_o !== 1'b0) begin failures++; $display("FAIL flush_gated got=%b exp=0", flush_req_o); end
    tick();
    en_i = 1;
    #1;
    checks++; if ({cycle_cnt_o, flush_req_o, done_o} !== {32'd150, 1'b1, 1'b0}) begin
      failures++; $display("FAIL flush_pulse got=%0d/%b/%b exp=150/1/0", cycle_cnt_o, flush_req_o, done_o); end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick(); #1;
      if (flush_req_o === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL flush_extra got=%0d exp=0", pulses); end
    checks++; if ({cycle_cnt_o, done_o} !== {32'd156, 1'b1}) begin
      failures++; $display("FAIL flush_done got=%0d/%b exp=156/1", cycle_cnt_o, done_o); end
    clr_i = 1; tick(); clr_i = 0;
    #1;
    checks++; if ({cycle_cnt_o, done_o} !== {32'd1, 1'b1}) begin
      failures++; $display("FAIL flush_clr got=%0d/%b exp=1/1", cycle_cnt_o, done_o); end
  endtask

  task automatic test_reset_mid_miss();
    do_reset();
    en_i = 1; mem_read_i = 1; addr_i = 32'h80; rdata_i = 32'h77; stall_i = 1; fsm_idle_i = 1;
    tick(); tick();
    #1;
    checks++; if (rd_miss_cnt_o !== 32'd1) begin failures++; $display("FAIL midmiss_once got=%0d exp=1", rd_miss_cnt_o); end
    rst_i = 1; tick(); rst_i = 0;
    #1;
    checks++; if ({rd_miss_cnt_o, evt_valid_o} !== {32'd0, 1'b0}) begin
      failures++; $display("FAIL midmiss_rst got=%0d/%b exp=0/0", rd_miss_cnt_o, evt_valid_o); end
    tick();
    #1;
    checks++; if ({rd_miss_cnt_o, evt_valid_o, evt_type_o} !== {32'd1, FIFO_EN, (FIFO_EN ? 3'd1 : 3'd0)}) begin
      failures++; $display("FAIL midmiss_new got=%0d/%b/%0d exp=1/%b", rd_miss_cnt_o, evt_valid_o, evt_type_o, FIFO_EN); end
    set_idle(1'b1);
    tick();
  endtask

  task automatic test_random();
    logic [159:0] exp_cnt;
    logic [98:0]  exp_pl;
    logic [3:0]   exp_fl;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      rst_i       = ($urandom_range(0, 199) == 0);
      clr_i       = ($urandom_range(0, 49) == 0);
      en_i        = ($urandom_range(0, 9) != 0);
      stall_i     = $urandom_range(0, 1);
      fsm_idle_i  = $urandom_range(0, 1);
      dirty_i     = $urandom_range(0, 1);
      mem_read_i  = ($urandom_range(0, 9) < 5);
      mem_write_i = ($urandom_range(0, 9) < 3);
      evt_ready_i = ($urandom_range(0, 9) < 4);
      addr_i      = $urandom;
      wdata_i     = $urandom;
      rdata_i     = $urandom;
      #1;
      exp_cnt = {m_rdh, m_rdm, m_wrh, m_wrm, m_wb};
      exp_fl  = {en_i && (m_cyc == FLUSH), m_done, m_q.size() > 0, m_ovf};
      exp_pl  = (m_q.size() > 0) ? {m_q[0].t, m_q[0].a, m_q[0].d, m_q[0].c} : 99'd0;
      checks++; if (cycle_cnt_o !== m_cyc) begin failures++; $display("FAIL rnd_cycle t=%0d got=%0d exp=%0d", i, cycle_cnt_o, m_cyc); end
      checks++; if ({rd_hit_cnt_o, rd_miss_cnt_o, wr_hit_cnt_o, wr_miss_cnt_o, wb_cnt_o} !== exp_cnt) begin
        failures++; $display("FAIL rnd_counters t=%0d got=%0h exp=%0h", i, {rd_hit_cnt_o, rd_miss_cnt_o, wr_hit_cnt_o, wr_miss_cnt_o, wb_cnt_o}, exp_cnt); end
      checks++; if ({flush_req_o, done_o, evt_valid_o, evt_overflow_o} !== exp_fl) begin
        failures++; $display("FAIL rnd_flags t=%0d got=%b exp=%b", i, {flush_req_o, done_o, evt_valid_o, evt_overflow_o}, exp_fl); end
      checks++; if ({evt_type_o, evt_addr_o, evt_data_o, evt_cycle_o} !== exp_pl) begin
        failures++; $display("FAIL rnd_payload t=%0d got=%0h exp=%0h", i, {evt_type_o, evt_addr_o, evt_data_o, evt_cycle_o}, exp_pl); end
      tick();
    end
    set_idle(1'b1);
  endtask

  initial begin
    #2;
    test_reset();
    test_read_hit();
    test_write_miss_wb();
    test_overflow();
    test_back_to_back();
    test_flush();
    test_reset_mid_miss();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
